// File: rtl/switch_value_entry.sv
// Pushbutton value entry: synchronize, debounce and edge-detect up/down/clear buttons,
// then step a 5-bit value driven onto A..E. Hold-to-repeat is built with SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN.
module switch_value_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned MAX_VALUE       = 31,
    parameter int unsigned WRAP            = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_clear,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic changed
);

    localparam int unsigned NB     = 3;
    localparam int unsigned BTN_UP = 0;
    localparam int unsigned BTN_DN = 1;
    localparam int unsigned BTN_CL = 2;
    localparam int unsigned VW     = 5;
    localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) || MAX_VALUE < 1 || MAX_VALUE > 31 ||
        WRAP > 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("switch_value_entry: parameter out of range");
    end

`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 2);
    typedef enum logic [1:0] {IDLE, HOLD_WAIT, HOLD_REPEAT} state_e;
    logic [TW-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {IDLE, HOLD_WAIT} state_e;
`endif

    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] deb_dly_q;
    logic [NB-1:0] press_q, press_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [VW-1:0] value_q, value_d;
    logic          changed_q, changed_d;
    logic          do_step;
    logic          step_down;
    logic          held;

    // One step in the given direction, wrapping or saturating at the bounds.
    function automatic logic [VW-1:0] step_value(input logic [VW-1:0] v, input logic down);
        logic [VW-1:0] maxv;
        maxv = VW'(MAX_VALUE);
        if (!down) begin
            if (v >= maxv) step_value = (WRAP != 0) ? '0 : v;
            else           step_value = v + VW'(1);
        end else begin
            if (v == '0)   step_value = (WRAP != 0) ? maxv : v;
            else           step_value = v - VW'(1);
        end
    endfunction

    // Debounce: count consecutive samples disagreeing with the accepted level.
    always_comb begin
        deb_d   = deb_q;
        press_d = deb_q & ~deb_dly_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign held = dir_q ? deb_q[BTN_DN] : deb_q[BTN_UP];

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        value_d   = value_q;
        do_step   = 1'b0;
        step_down = dir_q;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
        timer_d   = timer_q;
`endif
        if (press_q[BTN_CL]) begin
            value_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Simultaneous up and down presses cancel out.
                    if (press_q[BTN_UP] ^ press_q[BTN_DN]) begin
                        do_step   = 1'b1;
                        step_down = press_q[BTN_DN];
                        dir_d     = press_q[BTN_DN];
                        state_d   = HOLD_WAIT;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
                        timer_d   = TW'(1);
`endif
                    end
                end
                HOLD_WAIT: begin
                    if (!held) begin
                        state_d = IDLE;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
                    end else if (timer_q >= TW'(REPEAT_DELAY)) begin
                        do_step = 1'b1;
                        timer_d = TW'(1);
                        state_d = HOLD_REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
`endif
                    end
                end
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
                HOLD_REPEAT: begin
                    if (!held) begin
                        state_d = IDLE;
                    end else if (timer_q >= TW'(REPEAT_PERIOD)) begin
                        do_step = 1'b1;
                        timer_d = TW'(1);
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        if (do_step) begin
            value_d = step_value(value_q, step_down);
        end
        changed_d = (value_d != value_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            value_q   <= '0;
            changed_q <= 1'b0;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
            timer_q   <= '0;
`endif
        end else begin
            sync1_q   <= {btn_clear, btn_down, btn_up};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= press_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            state_q   <= state_d;
            dir_q     <= dir_d;
            value_q   <= value_d;
            changed_q <= changed_d;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign {A, B, C, D, E} = value_q;
    assign changed         = changed_q;

endmodule

// File: tb/tb_switch_value_entry.sv
// Directed bench for switch_value_entry; DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_switch_value_entry;

    logic clk = 1'b0;
    logic rst, bu, bd, bc;
    logic rst_s, su, sd, sc;
    logic a, b, c, d, e, chg;
    logic sa, sb, scc, sdd, se, schg;
    logic [4:0] val, sval;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign val  = {a, b, c, d, e};
    assign sval = {sa, sb, scc, sdd, se};

    switch_value_entry #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .MAX_VALUE(31), .WRAP(1)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_up(bu), .btn_down(bd), .btn_clear(bc),
        .A(a), .B(b), .C(c), .D(d), .E(e), .changed(chg)
    );

    switch_value_entry #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .MAX_VALUE(31), .WRAP(0)
    ) u_sat (
        .clk(clk), .rst(rst_s), .btn_up(su), .btn_down(sd), .btn_clear(sc),
        .A(sa), .B(sb), .C(scc), .D(sdd), .E(se), .changed(schg)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // which: 0 up, 1 down, 2 clear (main); 3 up, 4 down (saturating instance)
    task automatic press(input int which, output int pulses);
        pulses = 0;
        @(negedge clk);
        case (which)
            0: bu = 1'b1;
            1: bd = 1'b1;
            2: bc = 1'b1;
            3: su = 1'b1;
            default: sd = 1'b1;
        endcase
        repeat (10) begin
            @(posedge clk); #1;
            if ((which < 3) ? chg : schg) pulses++;
        end
        @(negedge clk);
        bu = 1'b0; bd = 1'b0; bc = 1'b0; su = 1'b0; sd = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if ((which < 3) ? chg : schg) pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_s = 1'b1;
        bu = 1'b0; bd = 1'b0; bc = 1'b0; su = 1'b0; sd = 1'b0; sc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (val !== 5'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", val); end
        checks++; if (chg !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", chg); end
        checks++; if (sval !== 5'd0) begin failures++; $display("FAIL reset_sat_value got=%0d exp=0", sval); end
        @(negedge clk);
        rst = 1'b0; rst_s = 1'b0;
    endtask

    task automatic test_single_press();
        int pulses = 0;
        int pedge  = -1;
        do_reset();
        @(negedge clk);
        bu = 1'b1;
        for (int cy = 0; cy < 30; cy++) begin
            @(posedge clk); #1;
            if (chg === 1'b1) begin
                pulses++;
                if (pedge < 0) pedge = cy;
            end
            if (cy == 9) bu = 1'b0;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        checks++; if (pedge != 7) begin failures++; $display("FAIL single_latency got=%0d exp=7", pedge); end
        checks++; if (val !== 5'b00001) begin failures++; $display("FAIL single_value got=%b exp=00001", val); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            bu = 1'b1;
            repeat (2) begin @(posedge clk); #1; if (chg === 1'b1) pulses++; end
            @(negedge clk);
            bu = 1'b0;
            repeat (3) begin @(posedge clk); #1; if (chg === 1'b1) pulses++; end
        end
        repeat (10) begin @(posedge clk); #1; if (chg === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
        checks++; if (val !== 5'd0) begin failures++; $display("FAIL glitch_value got=%0d exp=0", val); end
    endtask

    task automatic test_wrap();
        int p;
        do_reset();
        press(1, p);
        checks++; if (val !== 5'd31) begin failures++; $display("FAIL wrap_down0 got=%0d exp=31", val); end
        checks++; if (p != 1) begin failures++; $display("FAIL wrap_down0_pulses got=%0d exp=1", p); end
        press(0, p);
        checks++; if (val !== 5'd0) begin failures++; $display("FAIL wrap_up31 got=%0d exp=0", val); end
        checks++; if (p != 1) begin failures++; $display("FAIL wrap_up31_pulses got=%0d exp=1", p); end
        press(1, p);
        checks++; if (val !== 5'd31) begin failures++; $display("FAIL wrap_down_again got=%0d exp=31", val); end
        checks++; if (p != 1) begin failures++; $display("FAIL wrap_down_again_pulses got=%0d exp=1", p); end
    endtask

    task automatic test_saturate();
        int p;
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        press(4, p);
        checks++; if (sval !== 5'd0) begin failures++; $display("FAIL sat_down0 got=%0d exp=0", sval); end
        checks++; if (p != 0) begin failures++; $display("FAIL sat_down0_pulses got=%0d exp=0", p); end
        for (int i = 0; i < 31; i++) press(3, p);
        checks++; if (sval !== 5'd31) begin failures++; $display("FAIL sat_climb got=%0d exp=31", sval); end
        press(3, p);
        checks++; if (sval !== 5'd31) begin failures++; $display("FAIL sat_up31 got=%0d exp=31", sval); end
        checks++; if (p != 0) begin failures++; $display("FAIL sat_up31_pulses got=%0d exp=0", p); end
    endtask

    task automatic test_hold_repeat();
        int pulses = 0;
        int late   = 0;
        int pe [3] = '{-1, -1, -1};
        logic [4:0] exp_val;
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
        exp_val = 5'd8;
`else
        exp_val = 5'd1;
`endif
        do_reset();
        @(negedge clk);
        bu = 1'b1;
        for (int cy = 0; cy < 60; cy++) begin
            @(posedge clk); #1;
            if (chg === 1'b1) begin
                if (pulses < 3) pe[pulses] = cy;
                pulses++;
            end
            if (cy == 59) bu = 1'b0;
        end
        checks++; if (val !== exp_val) begin failures++; $display("FAIL hold_value got=%0d exp=%0d", val, exp_val); end
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
        checks++; if (pe[0] != 7) begin failures++; $display("FAIL hold_first_step got=%0d exp=7", pe[0]); end
        checks++; if (pe[1] != 27) begin failures++; $display("FAIL hold_first_repeat got=%0d exp=27", pe[1]); end
        checks++; if (pe[2] != 32) begin failures++; $display("FAIL hold_second_repeat got=%0d exp=32", pe[2]); end
`else
        checks++; if (pulses != 1) begin failures++; $display("FAIL hold_single_step got=%0d exp=1", pulses); end
`endif
        repeat (20) @(posedge clk);
        repeat (30) begin @(posedge clk); #1; if (chg === 1'b1) late++; end
        checks++; if (late != 0) begin failures++; $display("FAIL hold_after_release got=%0d exp=0", late); end
    endtask

    task automatic test_same_cycle();
        int pulses = 0;
        int p;
        do_reset();
        @(negedge clk);
        bu = 1'b1; bd = 1'b1;
        repeat (20) begin @(posedge clk); #1; if (chg === 1'b1) pulses++; end
        @(negedge clk);
        bu = 1'b0; bd = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (chg === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin failures++; $display("FAIL updown_pulses got=%0d exp=0", pulses); end
        checks++; if (val !== 5'd0) begin failures++; $display("FAIL updown_value got=%0d exp=0", val); end
        press(2, p);
        checks++; if (p != 0) begin failures++; $display("FAIL clear_at_zero_pulses got=%0d exp=0", p); end
    endtask

    task automatic test_clear_hold();
        int p;
        int extra = 0;
        do_reset();
        for (int i = 0; i < 8; i++) press(0, p);
        checks++; if (val !== 5'd8) begin failures++; $display("FAIL clear_setup got=%0d exp=8", val); end
        @(negedge clk);
        bu = 1'b1;
        for (int cy = 0; cy < 60; cy++) begin
            @(posedge clk); #1;
            if (cy == 7) begin
                checks++; if (val !== 5'd9 || chg !== 1'b1) begin failures++; $display("FAIL clear_hold_step got=%0d/%b exp=9/1", val, chg); end
            end
            if (cy == 16) begin
                checks++; if (val !== 5'd9) begin failures++; $display("FAIL clear_before got=%0d exp=9", val); end
            end
            if (cy == 17) begin
                checks++; if (val !== 5'd0 || chg !== 1'b1) begin failures++; $display("FAIL clear_accept got=%0d/%b exp=0/1", val, chg); end
            end
            if (cy > 17 && chg === 1'b1) extra++;
            if (cy == 9) bc = 1'b1;
            if (cy == 19) bc = 1'b0;
            if (cy == 59) bu = 1'b0;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL clear_no_repeat got=%0d exp=0", extra); end
        checks++; if (val !== 5'd0) begin failures++; $display("FAIL clear_final got=%0d exp=0", val); end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid_hold();
        int n;
        int p;
        do_reset();
`ifdef SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN
        @(negedge clk);
        bu = 1'b1;
`else
        for (int i = 0; i < 11; i++) press(0, p);
        @(negedge clk);
        bu = 1'b1;
`endif
        n = 0;
        while (n < 200 && val !== 5'd12) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (val !== 5'd12) begin failures++; $display("FAIL rsthold_reach got=%0d exp=12", val); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (val !== 5'd0 || chg !== 1'b0) begin failures++; $display("FAIL rsthold_clear got=%0d/%b exp=0/0", val, chg); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 6) begin
                checks++; if (val !== 5'd0) begin failures++; $display("FAIL rsthold_early got=%0d exp=0", val); end
            end
            if (k == 7) begin
                checks++; if (val !== 5'd1 || chg !== 1'b1) begin failures++; $display("FAIL rsthold_repress got=%0d/%b exp=1/1", val, chg); end
            end
        end
        @(negedge clk);
        bu = 1'b0;
        repeat (15) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_saturate();
        test_hold_repeat();
        test_same_cycle();
        test_clear_hold();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_value_entry.md
Name: switch_value_entry

Overview:
- Generates the 5-bit code that feeds the display and LED decode path (outputs A..E) from three pushbuttons instead of slide switches.
- Synchronizes, debounces and edge-detects the up, down and clear buttons.
- Steps a value counter on each press, with hold-to-repeat.
- Sits between the board buttons and the display/LED decoders.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable samples needed to accept a new button level (range 1..2^20).
- REPEAT_DELAY, 25000000: cycles a button must be held after its first step before auto-repeat starts.
- REPEAT_PERIOD, 5000000: cycles between auto-repeat steps.
- MAX_VALUE, 31: upper bound of the value (range 1..31).
- WRAP, 1: 1 = wrap at the bounds; 0 = saturate at the bounds.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  raw up button, active-high, asynchronous to clk.
- btn_down  input  1  raw down button, active-high, asynchronous to clk.
- btn_clear  input  1  raw clear button, active-high, asynchronous to clk.
- A  output  1  value bit 4 (MSB).
- B  output  1  value bit 3.
- C  output  1  value bit 2.
- D  output  1  value bit 1.
- E  output  1  value bit 0 (LSB).
- changed  output  1  one-cycle pulse in the cycle A..E take a new value.

Behaviour:
- Reset, synchronous active-high, sampled on the clk rising edge:
  - value = 0, so A..E = 0.
  - changed = 0.
  - Synchronizers, debounced levels and counters cleared.
  - FSM = IDLE.
  - Reset mid-hold or mid-debounce discards the pending press. A button still held after reset is accepted as a new press once debounced.
- Input path, per button:
  - Two-flop synchronizer.
  - Debounce counter resets whenever the synchronized level equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level flips.
  - Press event = debounced 0->1.
- Latency: a raw level held stable from edge 0 produces the value update and the changed pulse on edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- Step arithmetic (value is 5 bits):
  - Up at MAX_VALUE: goes to 0 if WRAP=1, otherwise holds.
  - Down at 0: goes to MAX_VALUE if WRAP=1, otherwise holds.
  - changed pulses only when the value actually differs.
- Priority within one cycle:
  - Clear press first: value = 0, FSM -> IDLE. changed = 1 only if value was nonzero.
  - Otherwise, if up and down press events occur in the same cycle: no step, FSM stays IDLE.
  - Otherwise a single up or down event steps the value.
- FSM (IDLE, HOLD_WAIT, HOLD_REPEAT; a dir register records up or down):
  - IDLE: on an up or down press, step once, latch dir, load the timer, go to HOLD_WAIT.
  - HOLD_WAIT: if the held button's debounced level falls, go to IDLE. When the timer reaches REPEAT_DELAY, step, reload the timer, go to HOLD_REPEAT.
  - HOLD_REPEAT: step every REPEAT_PERIOD cycles while the held button stays high. Release goes to IDLE.
  - In HOLD_* states, press events of the opposite button are ignored. Clear still applies.
- A..E are registered outputs, glitch-free, and are stable between changed pulses.

Optional Feature:
- Macro: SWITCH_VALUE_ENTRY_AUTO_REPEAT_EN.
- Defined: hold-to-repeat exactly as described under Behaviour.
- Undefined:
  - HOLD_REPEAT and the repeat timer are not built; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Each press yields exactly one step, regardless of hold time.
  - FSM returns to IDLE only on release; a new press is needed for the next step.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, MAX_VALUE=31, WRAP=1):
- Reset, then btn_up high for 10 cycles, then low -> changed pulses once at edge 7; {A,B,C,D,E}=00001; no further change.
- btn_up pulses of 2 cycles, repeated 5 times with 3-cycle gaps -> no changed pulse; value stays 0.
- From value 31, one up press -> value 0, changed=1. Then one down press -> value 31. With WRAP=0: up at 31 -> value stays 31, changed stays 0.
- Macro defined: hold btn_up for 60 cycles from value 0 -> first step at edge 7, repeats at 20 cycles after the first step then every 5 cycles; final value = 1+1+floor((60-7-20)/5) = 8. Macro undefined -> final value 1.
- Up and down debounced-press events in the same cycle -> no change. Clear pressed while holding up at value 9 -> value 0 on the accepting edge, no further repeat steps.
- Assert rst for 1 cycle during HOLD_REPEAT at value 12 -> next cycle A..E = 0 and changed = 0. btn_up still held -> step to 1 after 3+DEBOUNCE_CYCLES edges from reset release.
